alu_arbiter: RTL and testbench

Two-port round-robin arbiter and sequencer that shares one combinational ALU (32-bit, 5-bit function code) between two requesters, such as a scalar issue path and an address/loop-counter unit. It registers the granted operands, drives them to the ALU for one full cycle, captures the result and zero flag, and returns them on the granted requester's response channel. Each channel uses a valid/ready handshake.

---
 rtl/alu_arbiter.sv | 129 ++++++++++++
 tb/tb_alu_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter and sequencer that shares one combinational ALU between two
// valid/ready requesters: grant in IDLE, drive the ALU in EXEC, return the result in RESP.
module alu_arbiter #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset_n,

  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_A,
  input  logic [N-1:0] req0_B,
  input  logic [4:0]   req0_fn,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic [N-1:0] rsp0_R,
  output logic         rsp0_Z,

  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_A,
  input  logic [N-1:0] req1_B,
  input  logic [4:0]   req1_fn,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [N-1:0] rsp1_R,
  output logic         rsp1_Z,

  output logic [N-1:0] alu_A,
  output logic [N-1:0] alu_B,
  output logic [4:0]   alu_fn,
  input  logic [N-1:0] alu_R,
  input  logic         alu_Z,

  output logic         busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         state;
  logic           last_grant;
  logic           gnt_id;
  logic [N-1:0]   op_a;
  logic [N-1:0]   op_b;
  logic [4:0]     op_fn;
  logic [N-1:0]   res_r;
  logic           res_z;
  logic           grant0;
  logic           grant1;
  logic           rsp_done;

  // A tie goes to whichever requester was not granted last.
  always_comb begin
    // NOTE: default every combinational output first so no path can infer a latch.
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE) begin
      if (req0_valid && (!req1_valid || last_grant)) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  assign rsp_done = gnt_id ? rsp1_ready : rsp0_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      last_grant <= 1'b1;
      gnt_id     <= 1'b0;
      op_a       <= '0;
      op_b       <= '0;
      op_fn      <= '0;
      res_r      <= '0;
      res_z      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            op_a       <= grant1 ? req1_A  : req0_A;
            op_b       <= grant1 ? req1_B  : req0_B;
            op_fn      <= grant1 ? req1_fn : req0_fn;
            gnt_id     <= grant1;
            last_grant <= grant1;
            state      <= EXEC;
            busy       <= 1'b1;
          end
        end
        EXEC: begin
          res_r <= alu_R;
          res_z <= alu_Z;
          state <= RESP;
        end
        RESP: begin
          if (rsp_done) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  assign rsp0_valid = (state == RESP) && !gnt_id;
  assign rsp1_valid = (state == RESP) &&  gnt_id;

  // Both response ports always show the last captured result.
  assign rsp0_R = res_r;
  assign rsp0_Z = res_z;
  assign rsp1_R = res_r;
  assign rsp1_Z = res_z;

  assign alu_A  = op_a;
  assign alu_B  = op_b;
  assign alu_fn = op_fn;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: transaction-level model compared every cycle,
// plus literal expectations for the directed scenarios and a randomized phase.
module tb_alu_arbiter;

  logic        clk;
  logic        reset_n;
  logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_Z;
  logic [31:0] req0_A, req0_B, rsp0_R;
  logic [4:0]  req0_fn;
  logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_Z;
  logic [31:0] req1_A, req1_B, rsp1_R;
  logic [4:0]  req1_fn;
  logic [31:0] alu_A, alu_B, alu_R;
  logic [4:0]  alu_fn;
  logic        alu_Z;
  logic        busy;

  alu_arbiter #(.N(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_A(req0_A), .req0_B(req0_B),
    .req0_fn(req0_fn), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_R(rsp0_R),
    .rsp0_Z(rsp0_Z),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_A(req1_A), .req1_B(req1_B),
    .req1_fn(req1_fn), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_R(rsp1_R),
    .rsp1_Z(rsp1_Z),
    .alu_A(alu_A), .alu_B(alu_B), .alu_fn(alu_fn), .alu_R(alu_R), .alu_Z(alu_Z),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the shared ALU; the function set is arbitrary since codes pass through.
  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [4:0] f);
    case (f)
      5'b00001: return a + b;
      5'b10001: return a - b;
      5'b00010: return a & b;
      5'b00011: return a | b;
      5'b00100: return a ^ b;
      default:  return b;
    endcase
  endfunction

  always_comb begin
    alu_R = ref_alu(alu_A, alu_B, alu_fn);
    alu_Z = (alu_R == 32'd0);
  end

  typedef struct {
    int          id;
    int          grant_cyc;
    int          first_cyc;
    int          done_cyc;
    logic [31:0] r;
    logic        z;
  } rec_t;

  rec_t log_q[$];

  int errs;
  int checks;
  int cyc;

  // Model: at most one transaction in flight; age 0 = executing, age 1 = responding.
  bit          m_act;
  int          m_age;
  int          m_id;
  logic        m_last;
  logic [31:0] m_a, m_b, m_r;
  logic [4:0]  m_fn;
  logic        m_z;
  int          m_grant, m_first;
  bit          rand_on;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", name, got, exp, cyc, $time);
    end
  endtask

  task automatic model_reset();
    m_act = 0; m_age = 0; m_id = 0; m_last = 1'b1;
    m_a = '0; m_b = '0; m_fn = '0; m_r = '0; m_z = 1'b0;
  endtask

  task automatic monitor();
    logic e0, e1;
    rec_t rec;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        model_reset();
        continue;
      end
      cyc++;
      e0 = !m_act && req0_valid && (!req1_valid || m_last);
      e1 = !m_act && req1_valid && !e0;
      check("req0_ready", req0_ready, e0);
      check("req1_ready", req1_ready, e1);
      check("busy", busy, m_act);
      check("alu_A", alu_A, m_a);
      check("alu_B", alu_B, m_b);
      check("alu_fn", alu_fn, m_fn);
      check("rsp0_valid", rsp0_valid, m_act && m_age == 1 && m_id == 0);
      check("rsp1_valid", rsp1_valid, m_act && m_age == 1 && m_id == 1);
      check("rsp0_R", rsp0_R, m_r);
      check("rsp0_Z", rsp0_Z, m_z);
      check("rsp1_R", rsp1_R, m_r);
      check("rsp1_Z", rsp1_Z, m_z);
      if (!m_act) begin
        if (e0 || e1) begin
          m_id    = e1 ? 1 : 0;
          m_a     = e1 ? req1_A  : req0_A;
          m_b     = e1 ? req1_B  : req0_B;
          m_fn    = e1 ? req1_fn : req0_fn;
          m_last  = e1;
          m_act   = 1;
          m_age   = 0;
          m_grant = cyc;
        end
      end else if (m_age == 0) begin
        m_age   = 1;
        m_r     = ref_alu(m_a, m_b, m_fn);
        m_z     = (m_r == 32'd0);
        m_first = cyc + 1;
      end else if (m_id == 1 ? rsp1_ready : rsp0_ready) begin
        rec.id = m_id; rec.grant_cyc = m_grant; rec.first_cyc = m_first;
        rec.done_cyc = cyc; rec.r = m_r; rec.z = m_z;
        log_q.push_back(rec);
        m_act = 0;
      end
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge, with inputs scrambled.
  task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] f);
    logic r;
    if (id == 0) begin req0_valid = 1'b1; req0_A = a; req0_B = b; req0_fn = f; end
    else         begin req1_valid = 1'b1; req1_A = a; req1_B = b; req1_fn = f; end
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      r = (id == 0) ? req0_ready : req1_ready;
      @(posedge clk);
      if (r) begin
        #1;
        if (id == 0) begin
          req0_valid = 1'b0; req0_A = $urandom; req0_B = $urandom; req0_fn = 5'($urandom);
        end else begin
          req1_valid = 1'b0; req1_A = $urandom; req1_B = $urandom; req1_fn = 5'($urandom);
        end
        return;
      end
    end
    check("issue_timeout", 1'b1, 1'b0);
  endtask

  task automatic wait_log(input int n);
    for (int k = 0; k < 400; k++) begin
      if (log_q.size() >= n) return;
      @(posedge clk);
      #1;
    end
    check("log_timeout", 64'(log_q.size()), 64'(n));
  endtask

  task automatic rand_requester(input int id);
    logic [31:0] a, b;
    logic [4:0]  f;
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      f = ($urandom_range(0, 1) == 0) ? 5'b10001 : 5'($urandom);
      issue(id, a, b, f);
    end
  endtask

  int base;

  initial begin
    errs = 0; checks = 0; cyc = 0; rand_on = 0;
    reset_n = 1'b0;
    req0_valid = 0; req0_A = 0; req0_B = 0; req0_fn = 0; rsp0_ready = 1;
    req1_valid = 0; req1_A = 0; req1_B = 0; req1_fn = 0; rsp1_ready = 1;
    model_reset();
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    check("reset_busy", busy, 1'b0);
    check("reset_alu_A", alu_A, 32'd0);
    repeat (2) @(posedge clk);
    #1;

    // Single add: 5 + 3 = 8, response two cycles after the grant.
    base = log_q.size();
    issue(0, 32'd5, 32'd3, 5'b00001);
    wait_log(base + 1);
    if (log_q.size() > base) begin
      check("add_id", 64'(log_q[base].id), 64'd0);
      check("add_R", log_q[base].r, 32'd8);
      check("add_Z", log_q[base].z, 1'b0);
      check("add_latency", 64'(log_q[base].first_cyc - log_q[base].grant_cyc), 64'd2);
      check("add_done", 64'(log_q[base].done_cyc - log_q[base].grant_cyc), 64'd2);
    end

    // Subtract to zero on requester 1.
    base = log_q.size();
    issue(1, 32'd7, 32'd7, 5'b10001);
    wait_log(base + 1);
    if (log_q.size() > base) begin
      check("sub_id", 64'(log_q[base].id), 64'd1);
      check("sub_R", log_q[base].r, 32'd0);
      check("sub_Z", log_q[base].z, 1'b1);
    end

    // Reset in the middle of EXEC: everything returns to reset values asynchronously.
    base = log_q.size();
    issue(0, 32'hdead_beef, 32'h1234_5678, 5'b00100);
    #1;
    reset_n = 1'b0;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_req0_ready", req0_ready, 1'b0);
    check("rst_req1_ready", req1_ready, 1'b0);
    check("rst_rsp0_valid", rsp0_valid, 1'b0);
    check("rst_rsp1_valid", rsp1_valid, 1'b0);
    check("rst_alu_A", alu_A, 32'd0);
    check("rst_alu_B", alu_B, 32'd0);
    check("rst_alu_fn", alu_fn, 5'd0);
    check("rst_rsp0_R", rsp0_R, 32'd0);
    check("rst_rsp0_Z", rsp0_Z, 1'b0);
    check("rst_rsp1_R", rsp1_R, 32'd0);
    repeat (2) @(negedge clk);
    #2;
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rst_no_response", 64'(log_q.size()), 64'(base));

    // Round-robin tie from reset: grant order 0,1,0,1.
    base = log_q.size();
    fork
      begin issue(0, 32'd10, 32'd20, 5'b00001); issue(0, 32'd40, 32'd2, 5'b00001); end
      begin issue(1, 32'd9, 32'd4, 5'b10001);  issue(1, 32'd50, 32'd50, 5'b10001); end
    join
    wait_log(base + 4);
    if (log_q.size() >= base + 4) begin
      check("rr_id0", 64'(log_q[base].id),     64'd0);
      check("rr_id1", 64'(log_q[base + 1].id), 64'd1);
      check("rr_id2", 64'(log_q[base + 2].id), 64'd0);
      check("rr_id3", 64'(log_q[base + 3].id), 64'd1);
      check("rr_R0", log_q[base].r,     32'd30);
      check("rr_R1", log_q[base + 1].r, 32'd5);
      check("rr_R2", log_q[base + 2].r, 32'd42);
      check("rr_R3", log_q[base + 3].r, 32'd0);
      check("rr_Z3", log_q[base + 3].z, 1'b1);
    end

    // Backpressure on requester 0 while requester 1 waits.
    base = log_q.size();
    rsp0_ready = 1'b0;
    issue(0, 32'd100, 32'd1, 5'b00001);
    fork
      issue(1, 32'd3, 32'd6, 5'b00010);
      begin repeat (12) @(posedge clk); #1; rsp0_ready = 1'b1; end
    join
    wait_log(base + 2);
    if (log_q.size() >= base + 2) begin
      check("bp_id", 64'(log_q[base].id), 64'd0);
      check("bp_R", log_q[base].r, 32'd101);
      check("bp_held", 64'(log_q[base].done_cyc - log_q[base].first_cyc >= 10), 64'd1);
      check("bp_next_grant", 64'(log_q[base + 1].grant_cyc), 64'(log_q[base].done_cyc + 1));
      check("bp_R1", log_q[base + 1].r, 32'd2);
    end

    // Randomized traffic with random response backpressure.
    rand_on = 1;
    fork
      begin
        fork
          rand_requester(0);
          rand_requester(1);
        join
        rand_on = 0;
      end
      begin
        while (rand_on) begin
          @(posedge clk);
          #1;
          rsp0_ready = ($urandom_range(0, 3) != 0);
          rsp1_ready = ($urandom_range(0, 3) != 0);
        end
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    #1;
    check("final_idle", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
